// File: rtl/axi2core_pkg.sv
// axi2core_pkg: shared FSM state, AXI response/burst encodings and beat size for the axi2core bridge
package axi2core_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      RD_RESP,
      WR_DATA,
      WR_REQ,
      WR_WAIT,
      WR_RESP
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam int BEAT_BYTES = 4;

   function automatic logic [1:0] resp_of(input logic err);
      return err ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi2core_if.sv
// axi2core_if: AXI4 slave channels and core LSU port seen by the axi2core bridge
interface axi2core_if #(
   parameter int AXI4_ADDRESS_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH    = 32,
   parameter int AXI4_ID_WIDTH      = 16
);
   logic [AXI4_ID_WIDTH-1:0]      aw_id;
   logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr;
   logic [7:0]                    aw_len;
   logic [1:0]                    aw_burst;
   logic                          aw_valid;
   logic                          aw_ready;

   logic [AXI4_DATA_WIDTH-1:0]    w_data;
   logic [AXI4_DATA_WIDTH/8-1:0]  w_strb;
   logic                          w_last;
   logic                          w_valid;
   logic                          w_ready;

   logic [AXI4_ID_WIDTH-1:0]      b_id;
   logic [1:0]                    b_resp;
   logic                          b_valid;
   logic                          b_ready;

   logic [AXI4_ID_WIDTH-1:0]      ar_id;
   logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr;
   logic [7:0]                    ar_len;
   logic [1:0]                    ar_burst;
   logic                          ar_valid;
   logic                          ar_ready;

   logic [AXI4_ID_WIDTH-1:0]      r_id;
   logic [AXI4_DATA_WIDTH-1:0]    r_data;
   logic [1:0]                    r_resp;
   logic                          r_last;
   logic                          r_valid;
   logic                          r_ready;

   logic                          data_req;
   logic                          data_gnt;
   logic                          data_rvalid;
   logic [AXI4_ADDRESS_WIDTH-1:0] data_addr;
   logic                          data_we;
   logic [3:0]                    data_be;
   logic [31:0]                   data_wdata;
   logic [31:0]                   data_rdata;

   modport slave (
      input  aw_id, aw_addr, aw_len, aw_burst, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_valid,
      output w_ready,
      output b_id, b_resp, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_burst, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_valid,
      input  r_ready,
      output data_req, data_addr, data_we, data_be, data_wdata,
      input  data_gnt, data_rvalid, data_rdata
   );

   modport master (
      output aw_id, aw_addr, aw_len, aw_burst, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_burst, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_valid,
      output r_ready,
      input  data_req, data_addr, data_we, data_be, data_wdata,
      output data_gnt, data_rvalid, data_rdata
   );

endinterface

// File: rtl/axi2core_beat_gen.sv
// axi2core_beat_gen: holds the accepted burst, counts beats and steps the core address
module axi2core_beat_gen
   import axi2core_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load_i,
   input  logic          adv_i,
   input  logic [AW-1:0] addr_i,
   input  logic [7:0]    len_i,
   input  logic [1:0]    burst_i,
   output logic [AW-1:0] addr_o,
   output logic          last_o
);

   logic [7:0] len_q;
   logic [7:0] beat_q;
   logic [1:0] burst_q;

   // capture a new burst on accept, otherwise step beat/address after each completed beat
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_o  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         burst_q <= BURST_FIXED;
      end else if (load_i) begin
         addr_o  <= addr_i;
         len_q   <= len_i;
         beat_q  <= '0;
         burst_q <= burst_i;
      end else if (adv_i) begin
         beat_q <= beat_q + 8'd1;
         addr_o <= burst_q == BURST_FIXED ? addr_o : addr_o + AW'(BEAT_BYTES);
      end
   end

   assign last_o = beat_q == len_q;

endmodule

// File: rtl/axi2core.sv
// axi2core: AXI4 slave to core req/gnt/rvalid bridge, one transaction at a time, bursts split into 32-bit beats.
// Define AXI2CORE_BURST_EN to serve bursts; otherwise len!=0 bursts are answered with SLVERR without core access.
module axi2core
   import axi2core_pkg::*;
#(
   parameter int AXI4_ADDRESS_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH    = 32,
   parameter int AXI4_ID_WIDTH      = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   axi2core_if.slave  bus
);

   if (AXI4_DATA_WIDTH != 32) begin : g_dw_check
      $error("axi2core: only AXI4_DATA_WIDTH=32 is supported");
   end

   state_t                        state_q, state_d;
   logic                          rr_q;
   logic                          err_q;
   logic                          err_in;
   logic [AXI4_ID_WIDTH-1:0]      id_q;
   logic [31:0]                   wdata_q;
   logic [31:0]                   rdata_q;
   logic [3:0]                    strb_q;
   logic                          pick_rd;
   logic                          pick_wr;
   logic                          load;
   logic                          adv;
   logic                          last;
   logic [AXI4_ADDRESS_WIDTH-1:0] addr_sel;
   logic [7:0]                    len_sel;
   logic [1:0]                    burst_sel;
   logic                          unused_w_last;

   // w_last is informational only; the beat counter decides burst end
   assign unused_w_last = bus.w_last;

   // rr_q=0 favours reads when AR and AW arrive together
   assign pick_rd   = state_q == IDLE && bus.ar_valid && (!bus.aw_valid || !rr_q);
   assign pick_wr   = state_q == IDLE && bus.aw_valid && !pick_rd;
   assign load      = pick_rd || pick_wr;
   assign addr_sel  = pick_rd ? bus.ar_addr : bus.aw_addr;
   assign len_sel   = pick_rd ? bus.ar_len : bus.aw_len;
   assign burst_sel = pick_rd ? bus.ar_burst : bus.aw_burst;

`ifdef AXI2CORE_BURST_EN
   assign err_in = 1'b0;
`else
   assign err_in = len_sel != 8'd0;
`endif

   axi2core_beat_gen #(
      .AW(AXI4_ADDRESS_WIDTH)
   ) u_beat_gen (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load),
      .adv_i   (adv),
      .addr_i  (addr_sel),
      .len_i   (len_sel),
      .burst_i (burst_sel),
      .addr_o  (bus.data_addr),
      .last_o  (last)
   );

   // next-state and beat advance; error bursts bypass the core request states
   always_comb begin
      state_d = state_q;
      adv     = 1'b0;
      case (state_q)
         IDLE:    state_d = pick_rd ? (err_in ? RD_RESP : RD_REQ) : pick_wr ? WR_DATA : IDLE;
         RD_REQ:  state_d = bus.data_gnt ? RD_WAIT : RD_REQ;
         RD_WAIT: state_d = bus.data_rvalid ? RD_RESP : RD_WAIT;
         RD_RESP: begin
            adv     = bus.r_ready && !last;
            state_d = !bus.r_ready ? RD_RESP : last ? IDLE : err_q ? RD_RESP : RD_REQ;
         end
         WR_DATA: begin
            adv     = bus.w_valid && err_q && !last;
            state_d = !bus.w_valid ? WR_DATA : !err_q ? WR_REQ : last ? WR_RESP : WR_DATA;
         end
         WR_REQ:  state_d = bus.data_gnt ? WR_WAIT : WR_REQ;
         WR_WAIT: begin
            adv     = bus.data_rvalid && !last;
            state_d = !bus.data_rvalid ? WR_WAIT : last ? WR_RESP : WR_DATA;
         end
         WR_RESP: state_d = bus.b_ready ? IDLE : WR_RESP;
         default: state_d = IDLE;
      endcase
   end

   // state, arbitration bit and transaction/beat payload registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         err_q   <= 1'b0;
         id_q    <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            rr_q    <= ~rr_q;
            err_q   <= err_in;
            id_q    <= pick_rd ? bus.ar_id : bus.aw_id;
            rdata_q <= '0;
         end
         if (state_q == WR_DATA && bus.w_valid) begin
            wdata_q <= bus.w_data;
            strb_q  <= bus.w_strb;
         end
         if (state_q == RD_WAIT && bus.data_rvalid) rdata_q <= bus.data_rdata;
      end
   end

   assign bus.ar_ready   = pick_rd;
   assign bus.aw_ready   = pick_wr;
   assign bus.w_ready    = state_q == WR_DATA;
   assign bus.data_req   = state_q == RD_REQ || state_q == WR_REQ;
   assign bus.data_we    = state_q == WR_REQ;
   assign bus.data_be    = state_q == WR_REQ ? strb_q : state_q == RD_REQ ? 4'hF : 4'h0;
   assign bus.data_wdata = wdata_q;
   assign bus.r_valid    = state_q == RD_RESP;
   assign bus.r_data     = rdata_q;
   assign bus.r_resp     = resp_of(err_q);
   assign bus.r_last     = state_q == RD_RESP && last;
   assign bus.r_id       = id_q;
   assign bus.b_valid    = state_q == WR_RESP;
   assign bus.b_resp     = resp_of(err_q);
   assign bus.b_id       = id_q;

endmodule
